if_id_buf: RTL and testbench
============================

IF_ID_BUF -- requirements
Module: if_id_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning number of buffered fetch entries; legal values 2..8.
REQ-002 SHALL have parameter NOP_INST, default 32'h00000013, meaning instruction presented downstream when the buffer is empty.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port if_valid  input  1  fetch stage presents a valid pc/inst pair.
REQ-006 SHALL have port if_pc  input  64  address of the fetched instruction.
REQ-007 SHALL have port if_inst  input  32  fetched instruction word.
REQ-008 SHALL have port if_ready  output  1  buffer can accept an entry this cycle.
REQ-009 SHALL have port flush  input  1  discard all buffered entries (redirect or exception).
REQ-010 SHALL have port id_valid  output  1  head entry is valid for decode.
REQ-011 SHALL have port id_pc  output  64  pc of head entry.
REQ-012 SHALL have port id_inst  output  32  instruction of head entry.
REQ-013 SHALL have port id_ready  input  1  decode consumes the head entry this cycle.
REQ-014 SHALL have port occupancy  output  $clog2(DEPTH+1)  current entry count.

Function
REQ-015 SHALL implement a circular FIFO of DEPTH entries {pc[63:0], inst[31:0]} with read pointer, write pointer and count.
REQ-016 SHALL enqueue if_pc/if_inst at write pointer when if_valid && if_ready && !flush.
REQ-017 SHALL dequeue head when id_valid && id_ready && !flush.
REQ-018 SHALL drive if_ready = (count < DEPTH), decoded from registered count only; no combinational path from id_ready.
REQ-019 SHALL drive id_valid = (count != 0), decoded from registered count only; no combinational path from if_valid.
REQ-020 SHALL drive id_pc/id_inst from the head entry when id_valid=1, else 64'h0 and NOP_INST.
REQ-021 SHALL have enqueue-to-id_valid latency of exactly one cycle; no same-cycle bypass.
REQ-022 SHALL, on simultaneous enqueue and dequeue, keep count unchanged and advance both pointers.
REQ-023 SHALL, when full, present if_ready=0; a concurrent dequeue raises if_ready only in the following cycle.
REQ-024 SHALL wrap both pointers from DEPTH-1 to 0, non-power-of-two DEPTH included.
REQ-025 SHALL, when flush=1, set count, read pointer and write pointer to 0 next cycle, ignoring any same-cycle enqueue or dequeue.
REQ-026 SHALL never let count exceed DEPTH or underflow below 0.
REQ-027 SHALL drive occupancy = count.

Reset
REQ-028 SHALL, on reset assertion, immediately (asynchronously) clear count and both pointers, giving if_ready=1, id_valid=0, id_pc=0, id_inst=NOP_INST, occupancy=0.
REQ-029 SHALL discard in-flight entries on reset mid-operation; storage contents need not be cleared.
REQ-030 SHALL accept its first enqueue on the first rising edge after reset deasserts.

Structure
REQ-031 SHALL take XLEN=64, ILEN=32 and the NOP encoding 32'h00000013 from the shared core package.
REQ-032 SHALL be one flat module; no sub-module is warranted.

Verification
REQ-033 SHALL cover single pass: enqueue pc=0x80000000 inst=0x00000297, id_ready=1 -> id_valid next cycle with identical values; occupancy 1 then 0.
REQ-034 SHALL cover fill: id_ready=0, enqueue 0x80000000, 0x80000004 -> if_ready=0 at occupancy 2; third offer 0x80000008 not stored.
REQ-035 SHALL cover full with concurrent dequeue: at occupancy 2, id_ready=1 and if_valid=1 -> no enqueue that cycle; occupancy 1, if_ready=1 next.
REQ-036 SHALL cover flush: occupancy 2 plus flush=1 with if_valid=1 pc=0x80000100 -> next cycle occupancy 0, id_valid=0, id_inst=0x00000013.
REQ-037 SHALL cover streaming: 8 consecutive enqueues with id_ready=1 -> outputs in order, pointers wrap, occupancy stays 1.
REQ-038 SHALL cover reset mid-operation: assert reset at occupancy 2 between edges -> id_valid=0 and if_ready=1 before the next edge.

Source files
------------

// File: rtl/if_id_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_buf_pkg
// Description : Shared core constants and the fetch-entry record used by the
//               IF/ID decoupling buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package if_id_buf_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    // Canonical NOP: addi x0, x0, 0
    localparam logic [ILEN-1:0] NOP_ENC = 32'h00000013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } fetch_entry_t;

endpackage : if_id_buf_pkg
`default_nettype wire

// File: rtl/if_id_buf.sv
`default_nettype none
// ============================================================================
// Module      : if_id_buf
// Description : Circular FIFO between instruction fetch and decode. Handshake
//               outputs are decoded from the registered count only, so there
//               is no combinational path across the buffer in either
//               direction. Flush discards every buffered entry.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_buf
    import if_id_buf_pkg::*;
#(
    parameter int              DEPTH    = 2,
    parameter logic [ILEN-1:0] NOP_INST = NOP_ENC
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       if_valid,
    input  logic [XLEN-1:0]            if_pc,
    input  logic [ILEN-1:0]            if_inst,
    output logic                       if_ready,
    input  logic                       flush,
    output logic                       id_valid,
    output logic [XLEN-1:0]            id_pc,
    output logic [ILEN-1:0]            id_inst,
    input  logic                       id_ready,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int                 PTR_W  = $clog2(DEPTH);
    localparam int                 CNT_W  = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0]   C_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0]   C_LAST = PTR_W'(DEPTH - 1);

    fetch_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [CNT_W-1:0]    r_count;

    logic                w_enq;
    logic                w_deq;
    fetch_entry_t        w_head;

    // Explicit wrap so non-power-of-two depths never index past the last slot
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == C_LAST) ? '0 : p + 1'b1;
    endfunction

    assign if_ready  = (r_count < C_FULL);
    assign id_valid  = (r_count != '0);
    assign occupancy = r_count;

    assign w_enq  = if_valid && if_ready && !flush;
    assign w_deq  = id_valid && id_ready && !flush;
    assign w_head = r_mem[r_rd_ptr];

    assign id_pc   = id_valid ? w_head.pc   : '0;
    assign id_inst = id_valid ? w_head.inst : NOP_INST;

    // Pointer and count bookkeeping; flush overrides any same-cycle transfer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_deq) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            // Enqueue is gated by !full and dequeue by !empty, so the count
            // can neither overflow nor underflow here.
            unique case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents are don't-care until the count covers them
    always_ff @(posedge clock) begin
        if (w_enq) begin
            r_mem[r_wr_ptr] <= '{pc: if_pc, inst: if_inst};
        end
    end

endmodule : if_id_buf
`default_nettype wire

// File: tb/tb_if_id_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_buf
// Description : Self-checking bench for if_id_buf. Two instances (DEPTH 2 and
//               DEPTH 3) share stimulus; a queue-based model per instance
//               predicts handshake state and the head entry.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_buf;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } ent_t;

    localparam int DA = 2;
    localparam int DB = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_valid = 1'b0;
    logic [63:0] if_pc = '0;
    logic [31:0] if_inst = '0;
    logic        flush = 1'b0;
    logic        id_ready = 1'b0;

    logic        a_if_ready, a_id_valid;
    logic [63:0] a_id_pc;
    logic [31:0] a_id_inst;
    logic [1:0]  a_occ;
    logic        b_if_ready, b_id_valid;
    logic [63:0] b_id_pc;
    logic [31:0] b_id_inst;
    logic [1:0]  b_occ;

    int checks = 0;
    int passed = 0;

    ent_t qa[$];
    ent_t qb[$];

    if_id_buf #(.DEPTH(DA)) u_dut_a (
        .clock(clk), .reset(rst), .if_valid(if_valid), .if_pc(if_pc),
        .if_inst(if_inst), .if_ready(a_if_ready), .flush(flush),
        .id_valid(a_id_valid), .id_pc(a_id_pc), .id_inst(a_id_inst),
        .id_ready(id_ready), .occupancy(a_occ)
    );

    if_id_buf #(.DEPTH(DB)) u_dut_b (
        .clock(clk), .reset(rst), .if_valid(if_valid), .if_pc(if_pc),
        .if_inst(if_inst), .if_ready(b_if_ready), .flush(flush),
        .id_valid(b_id_valid), .id_pc(b_id_pc), .id_inst(b_id_inst),
        .id_ready(id_ready), .occupancy(b_occ)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    // Compare one instance against its model: reset forces the idle view
    task automatic check_dut(input string tag, input int depth, input int size, input ent_t head,
                             input logic v, input logic r, input logic [1:0] occ,
                             input logic [63:0] pc, input logic [31:0] inst);
        int   esz;
        ent_t eh;
        esz = rst ? 0 : size;
        eh  = (esz != 0) ? head : '{pc: 64'h0, inst: 32'h00000013};
        chk({tag, ".id_valid"},  96'(v),    96'(esz != 0));
        chk({tag, ".if_ready"},  96'(r),    96'(esz < depth));
        chk({tag, ".occupancy"}, 96'(occ),  96'(esz));
        chk({tag, ".id_pc"},     96'(pc),   96'(eh.pc));
        chk({tag, ".id_inst"},   96'(inst), 96'(eh.inst));
    endtask

    // Model: a FIFO of accepted entries; flush or reset empties it
    always @(posedge clk) begin
        bit   da, db, ea, eb;
        ent_t e;
        e = '{pc: if_pc, inst: if_inst};
        if (rst || flush) begin
            qa.delete();
            qb.delete();
        end else begin
            da = (qa.size() != 0) && id_ready;
            ea = if_valid && (qa.size() < DA);
            db = (qb.size() != 0) && id_ready;
            eb = if_valid && (qb.size() < DB);
            if (da) void'(qa.pop_front());
            if (ea) qa.push_back(e);
            if (db) void'(qb.pop_front());
            if (eb) qb.push_back(e);
        end
    end

    // Monitor: sample away from the rising edge and compare against the model
    always @(negedge clk) begin
        ent_t ha, hb;
        ha = (qa.size() != 0) ? qa[0] : '0;
        hb = (qb.size() != 0) ? qb[0] : '0;
        check_dut("A", DA, qa.size(), ha, a_id_valid, a_if_ready, a_occ, a_id_pc, a_id_inst);
        check_dut("B", DB, qb.size(), hb, b_id_valid, b_if_ready, b_occ, b_id_pc, b_id_inst);
    end

    // Apply one cycle of stimulus shortly after the rising edge
    task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] inst,
                         input logic rdy, input logic fl, input logic rs);
        if_valid = v;
        if_pc    = pc;
        if_inst  = inst;
        id_ready = rdy;
        flush    = fl;
        rst      = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) drive(1'b0, 64'h0, 32'h0, rdy, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset held across two edges, released between edges
        @(posedge clk); #1;
        drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        idle(1, 1'b0);

        // Single pass
        drive(1'b1, 64'h80000000, 32'h00000297, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b1);

        // Fill, then a third offer
        drive(1'b1, 64'h80000000, 32'h00000297, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 64'h80000004, 32'h00000317, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 64'h80000008, 32'h00000397, 1'b0, 1'b0, 1'b0);
        // Full with concurrent dequeue and offer
        drive(1'b1, 64'h8000000C, 32'h00000417, 1'b1, 1'b0, 1'b0);
        idle(4, 1'b1);

        // Flush with a same-cycle offer
        drive(1'b1, 64'h80000010, 32'h00000497, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 64'h80000014, 32'h00000517, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 64'h80000100, 32'h00000597, 1'b1, 1'b1, 1'b0);
        idle(2, 1'b1);

        // Streaming: eight back-to-back transfers
        for (int i = 0; i < 8; i++)
            drive(1'b1, 64'h80000200 + 64'(4 * i), 32'h00A00013 + 32'(i << 20), 1'b1, 1'b0, 1'b0);
        idle(3, 1'b1);

        // Reset mid-operation
        drive(1'b1, 64'h80000300, 32'h00100093, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 64'h80000304, 32'h00200113, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 64'h80000400, 32'h00300193, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic        v, rdy, fl, rs;
            logic [63:0] pc;
            logic [31:0] inst;
            v    = ($urandom_range(0, 99) < 70);
            rdy  = ($urandom_range(0, 99) < 55);
            fl   = ($urandom_range(0, 99) < 3);
            rs   = ($urandom_range(0, 199) == 0);
            pc   = {$urandom, $urandom};
            inst = $urandom;
            drive(v, pc, inst, rdy, fl, rs);
        end
        idle(4, 1'b1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_if_id_buf
`default_nettype wire
